// File: rtl/wsg_multi.sv
// wsg_multi: time-multiplexed wavetable voices, volume-scaled and mixed into one saturated sample per tick.
// Optional macro WSG_MUTE_EN adds mute_mask: muted voices add nothing but keep fetching and advancing phase.
module wsg_multi #(
  parameter int NUM_CH    = 3,
  parameter int CLK_HZ    = 47828000,
  parameter int SAMPLE_HZ = 24000,
  parameter int ACC_W     = 20,
  parameter int OUT_W     = 10
) (
  input  logic                        clk_pixel,
  input  logic                        reset_n,
  input  logic                        reg_we,
  input  logic [3+$clog2(NUM_CH)-1:0] reg_addr,
  input  logic [3:0]                  reg_din,
  output logic                        rom_rd,
  output logic [7:0]                  rom_addr,
  output logic                        rom_sel,
  input  logic [3:0]                  rom_data,
`ifdef WSG_MUTE_EN
  input  logic [NUM_CH-1:0]           mute_mask,
`endif
  output logic signed [OUT_W-1:0]     sample_out,
  output logic                        sample_valid,
  output logic                        overrun
);
  localparam int CHW  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int SW   = 9 + $clog2(NUM_CH);
  localparam int DIV  = CLK_HZ / SAMPLE_HZ;
  localparam int TW   = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SMAX = 2 ** (OUT_W - 1) - 1;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, ACC, OUT} state_t;
  state_t               state_q;
  logic [TW-1:0]        tcnt_q;
  logic [CHW-1:0]       ch_q, nch, wr_ch;
  logic signed [SW-1:0] sum_q;
  logic [3:0]           data_q, vol_eff;
  logic [19:0]          freq_q [NUM_CH];
  logic [3:0]           wave_q [NUM_CH];
  logic [3:0]           vol_q [NUM_CH];
  logic [ACC_W-1:0]     phase_q [NUM_CH];
  logic [ACC_W-1:0]     phase_d;
  logic signed [8:0]    dv, vv, contrib;
  logic                 tick, last, go_fetch;
  int                   sat;
  assign tick     = tcnt_q == TW'(DIV - 1);
  assign last     = int'(ch_q) == NUM_CH - 1;
  assign go_fetch = (state_q == IDLE && tick) || (state_q == ACC && !last);
  assign nch      = state_q == ACC && !last ? ch_q + CHW'(1) : '0;
  assign wr_ch    = CHW'(reg_addr >> 3);
`ifdef WSG_MUTE_EN
  assign vol_eff  = mute_mask[ch_q] ? 4'd0 : vol_q[ch_q];
`else
  assign vol_eff  = vol_q[ch_q];
`endif
  assign dv       = $signed({5'b0, data_q}) - 9'sd7;
  assign vv       = $signed({5'b0, vol_eff});
  assign contrib  = dv * vv;
  assign phase_d  = phase_q[ch_q] + ACC_W'(freq_q[ch_q]);
  always_comb begin
    sat = int'(sum_q);
    sat = sat > SMAX ? SMAX : sat < -SMAX - 1 ? -SMAX - 1 : sat;
  end
  always_ff @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        freq_q[i] <= '0;
        wave_q[i] <= '0;
        vol_q[i]  <= '0;
      end
    end else if (reg_we && int'(wr_ch) < NUM_CH) begin
      if (reg_addr[2:0] < 3'd5) freq_q[wr_ch][{reg_addr[2:0], 2'b00} +: 4] <= reg_din;
      else if (reg_addr[2:0] == 3'd5) wave_q[wr_ch] <= reg_din;
      else if (reg_addr[2:0] == 3'd6) vol_q[wr_ch] <= reg_din;
    end
  // Ticks landing anywhere but IDLE (OUT included) are dropped and flagged.
  always_ff @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) begin
      state_q      <= IDLE;
      tcnt_q       <= '0;
      ch_q         <= '0;
      sum_q        <= '0;
      data_q       <= '0;
      rom_rd       <= 1'b0;
      rom_addr     <= '0;
      rom_sel      <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) phase_q[i] <= '0;
    end else begin
      tcnt_q       <= tick ? '0 : tcnt_q + TW'(1);
      overrun      <= tick && state_q != IDLE;
      sample_valid <= state_q == OUT;
      rom_rd       <= go_fetch;
      if (go_fetch) begin
        rom_addr <= {wave_q[nch][2:0], phase_q[nch][ACC_W-1 -: 5]};
        rom_sel  <= wave_q[nch][3];
      end
      case (state_q)
        IDLE: if (tick) begin
          ch_q    <= '0;
          sum_q   <= '0;
          state_q <= FETCH;
        end
        FETCH: state_q <= WAIT;
        WAIT: begin
          data_q  <= rom_data;
          state_q <= ACC;
        end
        ACC: begin
          sum_q         <= sum_q + SW'(contrib);
          phase_q[ch_q] <= phase_d;
          ch_q          <= last ? ch_q : ch_q + CHW'(1);
          state_q       <= last ? OUT : FETCH;
        end
        OUT: begin
          sample_out <= OUT_W'(sat);
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_wsg_multi.sv
// tb_wsg_multi: directed checks of wsg_multi at default rate, in an 8-voice saturating build
// and in a build whose frame is longer than the tick period.
module tb_wsg_multi;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  logic              we = 1'b0, rd, sel, sv, ovr;
  logic [4:0]        addr = '0;
  logic [3:0]        din = '0, rdata = '0;
  logic [7:0]        raddr;
  logic signed [9:0] sout;
  logic              s_we = 1'b0, s_rd, s_sel, s_sv, s_ovr;
  logic [5:0]        s_addr = '0;
  logic [3:0]        s_din = '0, s_rdata = '0, s_const = '0;
  logic [7:0]        s_raddr;
  logic signed [9:0] s_out;
  logic              o_we = 1'b0, o_rd, o_sel, o_sv, o_ovr;
  logic [4:0]        o_addr = '0;
  logic [3:0]        o_din = '0, o_rdata = '0;
  logic [7:0]        o_raddr;
  logic signed [9:0] o_out;
`ifdef WSG_MUTE_EN
  logic [2:0]        mute = '0;
  logic [7:0]        s_mute = '0;
  logic [3:0]        o_mute = '0;
`endif
  int err = 0, chk = 0, ovr_cnt = 0;
  wsg_multi u_dut (
    .clk_pixel(clk), .reset_n(reset_n), .reg_we(we), .reg_addr(addr), .reg_din(din),
    .rom_rd(rd), .rom_addr(raddr), .rom_sel(sel), .rom_data(rdata),
`ifdef WSG_MUTE_EN
    .mute_mask(mute),
`endif
    .sample_out(sout), .sample_valid(sv), .overrun(ovr));
  wsg_multi #(.NUM_CH(8), .CLK_HZ(400), .SAMPLE_HZ(10)) u_sat (
    .clk_pixel(clk), .reset_n(reset_n), .reg_we(s_we), .reg_addr(s_addr), .reg_din(s_din),
    .rom_rd(s_rd), .rom_addr(s_raddr), .rom_sel(s_sel), .rom_data(s_rdata),
`ifdef WSG_MUTE_EN
    .mute_mask(s_mute),
`endif
    .sample_out(s_out), .sample_valid(s_sv), .overrun(s_ovr));
  wsg_multi #(.NUM_CH(4), .CLK_HZ(100), .SAMPLE_HZ(10)) u_ovr (
    .clk_pixel(clk), .reset_n(reset_n), .reg_we(o_we), .reg_addr(o_addr), .reg_din(o_din),
    .rom_rd(o_rd), .rom_addr(o_raddr), .rom_sel(o_sel), .rom_data(o_rdata),
`ifdef WSG_MUTE_EN
    .mute_mask(o_mute),
`endif
    .sample_out(o_out), .sample_valid(o_sv), .overrun(o_ovr));
  // PROM A is a sawtooth of the low address bits, PROM B is full scale.
  always @(posedge clk) if (rd) rdata <= sel ? 4'd15 : raddr[3:0];
  always @(posedge clk) if (s_rd) s_rdata <= s_const;
  always @(negedge clk) if (ovr === 1'b1) ovr_cnt++;

  task automatic wait_sv(input int which, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if ((which == 0 && sv) || (which == 1 && s_sv) || (which == 2 && o_sv)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_rd(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (rd) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wr(input logic [1:0] c, input logic [2:0] f, input logic [3:0] d);
    we = 1'b1; addr = {c, f}; din = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic swr(input logic [2:0] c, input logic [2:0] f, input logic [3:0] d);
    s_we = 1'b1; s_addr = {c, f}; s_din = d;
    @(negedge clk);
    s_we = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk++; if (sout !== 10'sd0) begin err++; $display("FAIL reset_sample got %0d exp 0", sout); end
    chk++; if (sv !== 1'b0) begin err++; $display("FAIL reset_valid got %b exp 0", sv); end
    chk++; if (rd !== 1'b0) begin err++; $display("FAIL reset_rom_rd got %b exp 0", rd); end
    chk++; if (ovr !== 1'b0) begin err++; $display("FAIL reset_overrun got %b exp 0", ovr); end
    reset_n = 1'b1;
    wait_sv(0, 2100, n);
    chk++; if (n != 2002) begin err++; $display("FAIL first_sample_latency got %0d exp 2002", n); end
    chk++; if (sout !== 10'sd0) begin err++; $display("FAIL first_sample_value got %0d exp 0", sout); end
  endtask

  task automatic test_rate;
    int n;
    for (int k = 0; k < 3; k++) begin
      wait_sv(0, 2100, n);
      chk++; if (n != 1992) begin err++; $display("FAIL rate_period%0d got %0d exp 1992", k, n); end
    end
  endtask

  task automatic test_sawtooth;
    int n, exp;
    wr(2'd0, 3'd6, 4'd15);
    wr(2'd0, 3'd3, 4'd8);
    for (int k = 0; k < 4; k++) begin
      wait_rd(2100, n);
      chk++; if (n < 0 || raddr !== 8'(k)) begin err++; $display("FAIL saw_addr%0d got %0d exp %0d", k, raddr, k); end
      chk++; if (sel !== 1'b0) begin err++; $display("FAIL saw_sel%0d got %b exp 0", k, sel); end
      wait_sv(0, 20, n);
      exp = 15 * (k - 7);
      chk++; if (n < 0 || sout !== 10'(exp)) begin err++; $display("FAIL saw_sample%0d got %0d exp %0d", k, sout, exp); end
    end
  endtask

  task automatic test_wave_b;
    int n;
    logic [7:0] ea;
    wr(2'd0, 3'd5, 4'd9);
    for (int k = 4; k < 6; k++) begin
      ea = {3'b001, 5'(k)};
      wait_rd(2100, n);
      chk++; if (n < 0 || raddr !== ea) begin err++; $display("FAIL waveb_addr%0d got %h exp %h", k, raddr, ea); end
      chk++; if (sel !== 1'b1) begin err++; $display("FAIL waveb_sel%0d got %b exp 1", k, sel); end
      wait_sv(0, 20, n);
      chk++; if (n < 0 || sout !== 10'sd120) begin err++; $display("FAIL waveb_sample%0d got %0d exp 120", k, sout); end
    end
  endtask

  task automatic test_midframe_write;
    int n;
    wr(2'd0, 3'd5, 4'd0);
    wait_rd(2100, n);
    @(negedge clk);
    @(negedge clk);
    we = 1'b1; addr = {2'd2, 3'd6}; din = 4'd8;
    @(negedge clk);
    we = 1'b0;
    wait_sv(0, 20, n);
    chk++; if (n < 0 || sout !== -10'sd71) begin err++; $display("FAIL midframe_sample got %0d exp -71", sout); end
    wait_sv(0, 2100, n);
    chk++; if (n < 0 || sout !== -10'sd56) begin err++; $display("FAIL midframe_next got %0d exp -56", sout); end
  endtask

`ifdef WSG_MUTE_EN
  task automatic test_mute;
    int n;
    mute = 3'b001;
    wait_rd(2100, n);
    chk++; if (n < 0 || raddr !== 8'd8) begin err++; $display("FAIL mute_addr got %0d exp 8", raddr); end
    wait_sv(0, 20, n);
    chk++; if (n < 0 || sout !== -10'sd56) begin err++; $display("FAIL mute_sample got %0d exp -56", sout); end
    mute = 3'b000;
  endtask
`endif

  task automatic test_saturation;
    int n;
    logic [3:0] cv [3] = '{4'd15, 4'd0, 4'd9};
    int ev [3] = '{511, -512, 240};
    for (int c = 0; c < 8; c++) swr(3'(c), 3'd6, 4'd15);
    for (int k = 0; k < 3; k++) begin
      s_const = cv[k];
      wait_sv(1, 100, n);
      wait_sv(1, 100, n);
      chk++; if (n != 40) begin err++; $display("FAIL sat_period%0d got %0d exp 40", k, n); end
      chk++; if (s_out !== 10'(ev[k])) begin err++; $display("FAIL sat_sample%0d got %0d exp %0d", k, s_out, ev[k]); end
    end
  endtask

  task automatic test_overrun;
    int n, nv = 0, no = 0;
    wait_sv(2, 40, n);
    wait_sv(2, 40, n);
    chk++; if (n != 20) begin err++; $display("FAIL ovr_period got %0d exp 20", n); end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_sv) nv++;
      if (o_ovr) no++;
    end
    chk++; if (nv != 5) begin err++; $display("FAIL ovr_valid_count got %0d exp 5", nv); end
    chk++; if (no != 5) begin err++; $display("FAIL ovr_pulse_count got %0d exp 5", no); end
  endtask

  task automatic test_reset_midframe;
    int n;
    wait_rd(2100, n);
    reset_n = 1'b0;
    #1;
    chk++; if (sout !== 10'sd0) begin err++; $display("FAIL midreset_sample got %0d exp 0", sout); end
    chk++; if (rd !== 1'b0) begin err++; $display("FAIL midreset_rom_rd got %b exp 0", rd); end
    chk++; if (sv !== 1'b0) begin err++; $display("FAIL midreset_valid got %b exp 0", sv); end
    chk++; if (s_out !== 10'sd0) begin err++; $display("FAIL midreset_sat_sample got %0d exp 0", s_out); end
    @(negedge clk);
    reset_n = 1'b1;
    wait_sv(0, 2100, n);
    chk++; if (n != 2002) begin err++; $display("FAIL midreset_latency got %0d exp 2002", n); end
    chk++; if (sout !== 10'sd0) begin err++; $display("FAIL midreset_value got %0d exp 0", sout); end
  endtask

  initial begin
    test_reset;
    test_rate;
    test_sawtooth;
    test_wave_b;
    test_midframe_write;
`ifdef WSG_MUTE_EN
    test_mute;
`endif
    test_saturation;
    test_overrun;
    test_reset_midframe;
    chk++; if (ovr_cnt != 0) begin err++; $display("FAIL default_overrun got %0d exp 0", ovr_cnt); end
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end
endmodule
